// File: rtl/rand_instr_gen.sv
// Random P5-subset MIPS program generator.
// Streams COUNT body words plus a two-word halt loop over valid/ready.
module rand_instr_gen #(
  parameter int unsigned COUNT   = 1024,
  parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_HALT0,
    S_HALT1,
    S_FIN
  } state_t;

  localparam logic [31:0] CNT    = 32'(COUNT);
  localparam logic [31:0] LAST   = CNT - 32'd1;
  localparam logic [31:0] HALT_W = 32'h1000_FFFF;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] idx;
  logic        prev_ctrl;

  logic        fire;
  logic [31:0] lfsr_nxt;

  logic [4:0]  k_raw;
  logic [4:0]  k;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [15:0] imm;
  logic [15:0] off_w;
  logic [15:0] off_h;
  logic [15:0] off_b;
  logic [3:0]  off;
  logic [31:0] reach;
  logic [31:0] tgt;
  logic [15:0] br_imm;
  logic [25:0] j_field;
  logic        is_ctrl_k;
  logic        gen_ctrl;
  logic [31:0] gen_word;

  function automatic logic [31:0] r_type(
    input logic [4:0] s,
    input logic [4:0] t,
    input logic [4:0] d,
    input logic [4:0] sa,
    input logic [5:0] fn
  );
    return {6'h00, s, t, d, sa, fn};
  endfunction

  function automatic logic [31:0] i_type(
    input logic [5:0]  op,
    input logic [4:0]  s,
    input logic [4:0]  t,
    input logic [15:0] im
  );
    return {op, s, t, im};
  endfunction

  assign fire     = out_valid & out_ready;
  assign lfsr_nxt = {1'b0, lfsr[31:1]}
                  ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);

  always_comb begin
    k_raw = lfsr[4:0];
    k     = (k_raw >= 5'd19) ? k_raw - 5'd19 : k_raw;
    rs    = {2'b0, lfsr[7:5]};
    rt    = {2'b0, lfsr[10:8]};
    rd    = {2'b0, lfsr[13:11]};
    sh    = lfsr[18:14];
    imm   = lfsr[31:16];
    off_w = {4'b0, lfsr[25:16], 2'b00};
    off_h = {4'b0, lfsr[26:16], 1'b0};
    off_b = {4'b0, lfsr[27:16]};
  end

  // Forward-only targets, clamped onto the halt loop at index COUNT.
  always_comb begin
    off     = {1'b0, lfsr[18:16]} + 4'd1;
    reach   = idx + 32'd1 + {28'b0, off};
    tgt     = (reach > CNT) ? CNT : reach;
    br_imm  = 16'(tgt - (idx + 32'd1));
    j_field = PC_BASE[27:2] + tgt[25:0];
  end

  always_comb begin
    gen_word = 32'h0;
    case (k)
      5'd0:  gen_word = r_type(rs, rt, rd, 5'd0, 6'h21);
      5'd1:  gen_word = r_type(rs, rt, rd, 5'd0, 6'h23);
      5'd2:  gen_word = i_type(6'h0d, rs, rt, imm);
      5'd3:  gen_word = i_type(6'h0f, 5'd0, rt, imm);
      5'd4:  gen_word = i_type(6'h23, 5'd0, rt, off_w);
      5'd5:  gen_word = i_type(6'h2b, 5'd0, rt, off_w);
      5'd6:  gen_word = i_type(6'h04, rs, rt, br_imm);
      5'd7:  gen_word = {6'h02, j_field};
      5'd8:  gen_word = {6'h03, j_field};
      5'd9:  gen_word = i_type(6'h20, 5'd0, rt, off_b);
      5'd10: gen_word = i_type(6'h28, 5'd0, rt, off_b);
      5'd11: gen_word = i_type(6'h21, 5'd0, rt, off_h);
      5'd12: gen_word = i_type(6'h29, 5'd0, rt, off_h);
      5'd13: gen_word = i_type(6'h24, 5'd0, rt, off_b);
      5'd14: gen_word = i_type(6'h25, 5'd0, rt, off_h);
      5'd15: gen_word = r_type(rs, rt, rd, 5'd0, 6'h2a);
      5'd16: gen_word = r_type(5'd0, rt, rd, sh, 6'h00);
      5'd17: gen_word = r_type(rs, rt, rd, 5'd0, 6'h04);
      5'd18: gen_word = i_type(6'h08, rs, rt, imm);
      default: gen_word = 32'h0;
    endcase
  end

  // A control word right after another becomes a nop in its delay slot.
  assign is_ctrl_k = (k == 5'd6) | (k == 5'd7) | (k == 5'd8);
  assign gen_ctrl  = is_ctrl_k & ~prev_ctrl;

  always_comb begin
    out_instr = 32'h0;
    unique case (1'b1)
      state == S_GEN:   out_instr = (prev_ctrl & is_ctrl_k)
                                    ? 32'h0 : gen_word;
      state == S_HALT0: out_instr = HALT_W;
      default:          out_instr = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      lfsr      <= 32'h1;
      idx       <= 32'h0;
      prev_ctrl <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= PC_BASE;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (start) begin
            state     <= S_GEN;
            lfsr      <= (seed == 32'h0) ? 32'h1 : seed;
            idx       <= 32'h0;
            prev_ctrl <= 1'b0;
            out_valid <= 1'b1;
            out_pc    <= PC_BASE;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_GEN: begin
          if (fire) begin
            lfsr      <= lfsr_nxt;
            idx       <= idx + 32'd1;
            prev_ctrl <= gen_ctrl;
            out_pc    <= out_pc + 32'd4;
            if (idx == LAST) state <= S_HALT0;
          end
        end
        S_HALT0: begin
          if (fire) begin
            state  <= S_HALT1;
            out_pc <= out_pc + 32'd4;
          end
        end
        S_HALT1: begin
          if (fire) begin
            state     <= S_FIN;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_instr_gen.sv
// Directed bench for rand_instr_gen.
// Hand-derived words for COUNT=4 and COUNT=1 instances.
module tb_rand_instr_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] seed;
  logic        out_ready;

  logic        a_valid;
  logic [31:0] a_instr;
  logic [31:0] a_pc;
  logic        a_busy;
  logic        a_done;

  logic        b_valid;
  logic [31:0] b_instr;
  logic [31:0] b_pc;
  logic        b_busy;
  logic        b_done;

  int checks;
  int errors;

  logic [31:0] wq[$];
  logic [31:0] pq[$];
  logic [31:0] exp_w[6];
  logic [31:0] t_seed[10];
  logic [31:0] t_exp[10];

  rand_instr_gen #(.COUNT(4), .PC_BASE(32'h0000_3000)) dut_a (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .out_ready(out_ready), .out_valid(a_valid),
    .out_instr(a_instr), .out_pc(a_pc),
    .busy(a_busy), .done(a_done)
  );

  rand_instr_gen #(.COUNT(1), .PC_BASE(32'h0000_3000)) dut_b (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .out_ready(out_ready), .out_valid(b_valid),
    .out_instr(b_instr), .out_pc(b_pc),
    .busy(b_busy), .done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    start = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] s);
    seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    wq.delete();
    pq.delete();
    out_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (a_done) begin
        out_ready = 1'b0;
        return;
      end
      if (a_valid) begin
        wq.push_back(a_instr);
        pq.push_back(a_pc);
      end
      tick();
    end
    out_ready = 1'b0;
    chk("drain_timeout", 32'(a_done), 32'h1);
  endtask

  task automatic cmp_stream(input string tag, input int first);
    chk({tag, "_n"}, 32'(wq.size()), 32'(6 - first));
    for (int i = 0; i < wq.size() && i < 6 - first; i++) begin
      chk({tag, "_w"}, wq[i], exp_w[first + i]);
      chk({tag, "_pc"}, pq[i], 32'h3000 + 32'(4 * (first + i)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_w = '{32'h0000_0023, 32'h3C00_8020, 32'h3400_C030,
              32'h0000_0023, 32'h1000_FFFF, 32'h0000_0000};
    t_seed = '{32'h0000_FFF4, 32'h0FFF_0004, 32'h0FFF_000A,
               32'h0FFF_000B, 32'h0007_C010, 32'h0000_0007,
               32'h0000_0008, 32'h1234_0012, 32'hABCD_0016,
               32'h0000_0006};
    t_exp = '{32'h00E7_3823, 32'h8C00_0FFC, 32'hA000_0FFF,
              32'h8400_0FFE, 32'h0000_07C0, 32'h0800_0C02,
              32'h0C00_0C02, 32'h2000_1234, 32'h3C00_ABCD,
              32'h1000_0001};
    reset = 1'b1;
    start = 1'b0;
    seed = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(a_valid), 32'h0);
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_pc", a_pc, 32'h3000);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_done", 32'(a_done), 32'h0);
    reset = 1'b0;
    tick();

    // full run, seed 0
    do_start(32'h0);
    chk("first_valid", 32'(a_valid), 32'h1);
    chk("first_busy", 32'(a_busy), 32'h1);
    drain(40);
    cmp_stream("run", 0);
    chk("fin_done", 32'(a_done), 32'h1);
    chk("fin_busy", 32'(a_busy), 32'h0);
    repeat (3) tick();
    chk("fin_valid", 32'(a_valid), 32'h0);

    // stall mid-GEN, with an ignored start
    do_start(32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    seed = 32'h1234_5678;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_w", a_instr, 32'h3C00_8020);
      chk("hold_pc", a_pc, 32'h3004);
    end
    start = 1'b0;
    drain(40);
    cmp_stream("hold", 1);

    // delay slot and clamped branch via forced lfsr
    do_start(32'h0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    force dut_a.lfsr = 32'h0007_0006;
    #1;
    chk("beq_clamp", a_instr, 32'h1000_0001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    force dut_a.lfsr = 32'h0000_0007;
    #1;
    chk("dslot_w", a_instr, 32'h0);
    chk("dslot_pc", a_pc, 32'h300C);
    release dut_a.lfsr;
    drain(40);
    chk("dslot_n", 32'(wq.size()), 32'h3);
    if (wq.size() == 3) begin
      chk("dslot_h0", wq[1], 32'h1000_FFFF);
      chk("dslot_h1", wq[2], 32'h0);
    end

    // first-word encodings
    for (int i = 0; i < 10; i++) begin
      do_reset();
      do_start(t_seed[i]);
      chk($sformatf("enc%0d", i), a_instr, t_exp[i]);
    end

    // COUNT=1: branch at idx 0 lands on the halt loop
    do_reset();
    do_start(32'h0000_0006);
    chk("c1_w0", b_instr, 32'h1000_0000);
    chk("c1_pc0", b_pc, 32'h3000);
    out_ready = 1'b1;
    tick();
    chk("c1_w1", b_instr, 32'h1000_FFFF);
    chk("c1_pc1", b_pc, 32'h3004);
    tick();
    chk("c1_w2", b_instr, 32'h0);
    tick();
    chk("c1_done", 32'(b_done), 32'h1);
    chk("c1_valid", 32'(b_valid), 32'h0);
    out_ready = 1'b0;

    // async reset mid-program, then replay
    do_reset();
    do_start(32'h0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(a_valid), 32'h0);
    chk("arst_busy", 32'(a_busy), 32'h0);
    chk("arst_instr", a_instr, 32'h0);
    chk("arst_pc", a_pc, 32'h3000);
    tick();
    reset = 1'b0;
    do_start(32'h0);
    drain(40);
    cmp_stream("replay", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
